// File: rtl/mips5_mem_pkg.sv
// rtl/mips5_mem_pkg.sv - shared requester IDs and memory geometry for the memory port arbiter
package mips5_mem_pkg;

   localparam logic [1:0] ID_I    = 2'd0;
   localparam logic [1:0] ID_D    = 2'd1;
   localparam logic [1:0] ID_G    = 2'd2;
   localparam logic [1:0] ID_NONE = 2'd3;

   localparam int MEM_AW = 9;
   localparam int MEM_DW = 32;

endpackage

// File: rtl/rr2_arb.sv
// rtl/rr2_arb.sv - two-input round-robin between fetch (bit 0) and load/store (bit 1)
module rr2_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_en,
   output logic [1:0] o_gnt
);

   // 1 = last I/D winner was D; resets to D so the first contention goes to I
   logic r_last_d;

   always_comb begin
      o_gnt = 2'b00;
      if (i_en) begin
         case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_last_d ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_d <= 1'b1;
      end else if (|o_gnt) begin
         r_last_d <= o_gnt[1];
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch, load/store and debug requesters
module mem_port_arbiter
   import mips5_mem_pkg::*;
#(
   parameter int AW    = MEM_AW,
   parameter int DW    = MEM_DW,
   parameter int G_MAX = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_gnt,
   output logic          i_rvalid,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   input  logic          g_req,
   input  logic          g_we,
   input  logic [AW-1:0] g_addr,
   input  logic [DW-1:0] g_wdata,
   output logic          g_gnt,
   output logic          g_rvalid,
   output logic [DW-1:0] g_rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_wen,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout,
   output logic          cpu_stall
);

   localparam logic [3:0] G_MAX_C = 4'(G_MAX);

   logic [3:0] r_g_cnt;
   logic       r_i_rvalid, r_d_rvalid, r_g_rvalid;
   logic [DW-1:0] r_i_rdata, r_d_rdata, r_g_rdata;

   logic       w_g_masked;
   logic       w_g_win;
   logic       w_id_en;
   logic [1:0] w_id_gnt;
   logic [1:0] w_win_id;
   logic       w_i_rd, w_d_rd, w_g_rd;

   // Gating with rst_n keeps every grant, and so every memory write, off during reset
   assign w_g_masked = (r_g_cnt == G_MAX_C);
   assign w_g_win    = rst_n & g_req & ~w_g_masked;
   assign w_id_en    = rst_n & ~w_g_win;

   rr2_arb u_rr2_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req ({d_req, i_req}),
      .i_en  (w_id_en),
      .o_gnt (w_id_gnt)
   );

   always_comb begin
      w_win_id = ID_NONE;
      if (w_g_win)          w_win_id = ID_G;
      else if (w_id_gnt[0]) w_win_id = ID_I;
      else if (w_id_gnt[1]) w_win_id = ID_D;
   end

   assign i_gnt = (w_win_id == ID_I);
   assign d_gnt = (w_win_id == ID_D);
   assign g_gnt = (w_win_id == ID_G);

   always_comb begin
      mem_addr = '0;
      mem_din  = '0;
      mem_wen  = 1'b0;
      case (w_win_id)
         ID_I: mem_addr = i_addr;
         ID_D: begin
            mem_addr = d_addr;
            mem_din  = d_wdata;
            mem_wen  = d_we;
         end
         ID_G: begin
            mem_addr = g_addr;
            mem_din  = g_wdata;
            mem_wen  = g_we;
         end
         default: mem_addr = '0;
      endcase
   end

   assign cpu_stall = (i_req & ~i_gnt) | (d_req & ~d_gnt);

   assign w_i_rd = i_gnt;
   assign w_d_rd = d_gnt & ~d_we;
   assign w_g_rd = g_gnt & ~g_we;

   // Streak counts only G grants that actually hold I/D off
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_g_cnt <= 4'd0;
      end else if (w_g_win & (i_req | d_req)) begin
         r_g_cnt <= r_g_cnt + 4'd1;
      end else begin
         r_g_cnt <= 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_i_rvalid <= 1'b0;
         r_d_rvalid <= 1'b0;
         r_g_rvalid <= 1'b0;
         r_i_rdata  <= '0;
         r_d_rdata  <= '0;
         r_g_rdata  <= '0;
      end else begin
         r_i_rvalid <= w_i_rd;
         r_d_rvalid <= w_d_rd;
         r_g_rvalid <= w_g_rd;
         if (w_i_rd) r_i_rdata <= mem_dout;
         if (w_d_rd) r_d_rdata <= mem_dout;
         if (w_g_rd) r_g_rdata <= mem_dout;
      end
   end

   assign i_rvalid = r_i_rvalid;
   assign d_rvalid = r_d_rvalid;
   assign g_rvalid = r_g_rvalid;
   assign i_rdata  = r_i_rdata;
   assign d_rdata  = r_d_rdata;
   assign g_rdata  = r_g_rdata;

endmodule
